// File: rtl/glb_bank_arbiter.sv
// Three-requester arbiter in front of one global-buffer bank: grants one command per cycle,
// registers it to the bank, and routes read returns back by tag. Define GLB_BANK_ARB_RR_EN for round-robin.
module glb_bank_arbiter #(
    parameter int BANK_ADDR_WIDTH = 17,
    parameter int BANK_DATA_WIDTH = 64,
    parameter int RD_LATENCY      = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   req_valid,
    input  logic [2:0]                   req_wr,
    input  logic [3*BANK_ADDR_WIDTH-1:0] req_addr,
    input  logic [3*BANK_DATA_WIDTH-1:0] req_data,
    input  logic [3*BANK_DATA_WIDTH-1:0] req_bit_sel,
    output logic [2:0]                   req_gnt,
    output logic [BANK_DATA_WIDTH-1:0]   rd_data,
    output logic [2:0]                   rd_valid,
    output logic                         mem_ren,
    output logic                         mem_wen,
    output logic [BANK_ADDR_WIDTH-1:0]   mem_addr,
    output logic [BANK_DATA_WIDTH-1:0]   mem_data_in,
    output logic [BANK_DATA_WIDTH-1:0]   mem_bit_sel,
    input  logic [BANK_DATA_WIDTH-1:0]   mem_rd_data,
    output logic [2:0]                   rd_pending
);
    localparam int TAG_STAGES = RD_LATENCY + 1;

    logic [2:0]                 gnt_raw;
    logic                       accept;
    logic                       win_wr;
    logic [1:0]                 win_id;
    logic [BANK_ADDR_WIDTH-1:0] win_addr;
    logic [BANK_DATA_WIDTH-1:0] win_data;
    logic [BANK_DATA_WIDTH-1:0] win_bit_sel;
    logic                       retire;

    logic       tag_vld_p [TAG_STAGES];
    logic [1:0] tag_id_p  [TAG_STAGES];

    // Counter never exceeds the tag pipeline depth and never goes below zero.
    function automatic logic [2:0] next_pending(input logic [2:0] cur, input logic inc, input logic dec);
        if (inc && !dec && cur < 3'(TAG_STAGES))
            return cur + 3'd1;
        if (dec && !inc && cur != 3'd0)
            return cur - 3'd1;
        return cur;
    endfunction

`ifdef GLB_BANK_ARB_RR_EN
    logic [1:0] ptr;

    function automatic logic [1:0] wrap_inc(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    always_comb begin
        logic [1:0] idx;
        gnt_raw = '0;
        idx     = ptr;
        for (int k = 0; k < 3; k++) begin
            if (gnt_raw == 3'b000 && req_valid[idx])
                gnt_raw[idx] = 1'b1;
            idx = wrap_inc(idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= 2'd0;
        else if (accept)
            ptr <= wrap_inc(win_id);
    end
`else
    always_comb begin
        gnt_raw = '0;
        if (req_valid[0])
            gnt_raw = 3'b001;
        else if (req_valid[1])
            gnt_raw = 3'b010;
        else if (req_valid[2])
            gnt_raw = 3'b100;
    end
`endif

    assign req_gnt = reset ? 3'b000 : gnt_raw;
    assign accept  = |req_gnt;

    always_comb begin
        win_id      = 2'd0;
        win_wr      = 1'b0;
        win_addr    = '0;
        win_data    = '0;
        win_bit_sel = '0;
        for (int i = 0; i < 3; i++) begin
            if (req_gnt[i]) begin
                win_id      = 2'(i);
                win_wr      = req_wr[i];
                win_addr    = req_addr[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
                win_data    = req_data[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
                win_bit_sel = req_bit_sel[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
            end
        end
    end

    // Stage 0: command register to the bank; tag pipeline tracks reads until data returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ren     <= 1'b0;
            mem_wen     <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_bit_sel <= '0;
            rd_pending  <= 3'd0;
            for (int s = 0; s < TAG_STAGES; s++) begin
                tag_vld_p[s] <= 1'b0;
                tag_id_p[s]  <= 2'd0;
            end
        end else begin
            mem_ren <= accept & ~win_wr;
            mem_wen <= accept & win_wr;
            if (accept) begin
                mem_addr    <= win_addr;
                mem_data_in <= win_data;
                mem_bit_sel <= win_bit_sel;
            end
            tag_vld_p[0] <= accept & ~win_wr;
            tag_id_p[0]  <= win_id;
            for (int s = 1; s < TAG_STAGES; s++) begin
                tag_vld_p[s] <= tag_vld_p[s-1];
                tag_id_p[s]  <= tag_id_p[s-1];
            end
            rd_pending <= next_pending(rd_pending, accept & ~win_wr, retire);
        end
    end

    // Final stage lines up with the bank's read data.
    assign retire   = tag_vld_p[RD_LATENCY];
    assign rd_valid = retire ? (3'b001 << tag_id_p[RD_LATENCY]) : 3'b000;
    assign rd_data  = mem_rd_data;

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// Bench for glb_bank_arbiter: bank memory environment, per-cycle reference model and directed scenarios.
module tb_glb_bank_arbiter;
    localparam int AW  = 17;
    localparam int DW  = 64;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [2:0]     req_valid, req_wr;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_data, req_bit_sel;
    logic [2:0]     req_gnt, rd_valid, rd_pending;
    logic [DW-1:0]  rd_data, mem_data_in, mem_bit_sel, mem_rd_data;
    logic           mem_ren, mem_wen;
    logic [AW-1:0]  mem_addr;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    glb_bank_arbiter #(.BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .req_bit_sel(req_bit_sel),
        .req_gnt(req_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_bit_sel(mem_bit_sel),
        .mem_rd_data(mem_rd_data), .rd_pending(rd_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_val(input logic [AW-1:0] a);
        return (a == 17'h100) ? 64'hA5A5 : (64'h1000_0000_0000_0000 | 64'(a));
    endfunction

    // Bank memory environment: writes take effect at the edge, reads return LAT cycles after mem_ren.
    logic [63:0] env_mem [logic [AW-1:0]];
    logic [63:0] mpipe [LAT];
    assign mem_rd_data = mpipe[LAT-1];

    function automatic logic [63:0] env_rd(input logic [AW-1:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_val(a);
    endfunction

    initial begin
        for (int i = 0; i < LAT; i++) mpipe[i] = '0;
        forever begin
            @(posedge clk);
            for (int i = LAT-1; i > 0; i--) mpipe[i] = mpipe[i-1];
            if (mem_ren) mpipe[0] = env_rd(mem_addr);
            if (mem_wen) env_mem[mem_addr] = (env_rd(mem_addr) & ~mem_bit_sel) | (mem_data_in & mem_bit_sel);
        end
    end

    // Reference model: transaction-level view of grants, commands and read returns.
    typedef struct { int due; int id; logic [63:0] data; } rd_t;
    rd_t         exp_q[$];
    logic [63:0] ref_mem [logic [AW-1:0]];
    int          ptr_m = 0;
    int          cyc   = 0;
    logic        exp_ren = 0, exp_wen = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [63:0] exp_din = '0, exp_bsel = '0;

    function automatic logic [63:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [2:0] model_gnt(input logic [2:0] v, input int p);
`ifdef GLB_BANK_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            int j = (p + k) % 3;
            if (v[2'(j)]) return 3'(1 << j);
        end
`else
        for (int j = 0; j < 3; j++)
            if (v[2'(j)]) return 3'(1 << j);
`endif
        return 3'b000;
    endfunction

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            logic [2:0]  eg, erv;
            logic [63:0] erd;
            logic [AW-1:0] a;
            if (reset) begin
                exp_q.delete();
                exp_ren = 0; exp_wen = 0; exp_addr = '0; exp_din = '0; exp_bsel = '0;
                ptr_m = 0;
            end
            eg  = reset ? 3'b000 : model_gnt(req_valid, ptr_m);
            erv = 3'b000;
            erd = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                erv = 3'(1 << exp_q[0].id);
                erd = exp_q[0].data;
            end
            chk("m_gnt", req_gnt, eg);
            chk("m_rd_valid", rd_valid, erv);
            if (erv != 3'b000) chk("m_rd_data", rd_data, erd);
            chk("m_rd_pending", rd_pending, 64'(exp_q.size()));
            chk("m_mem_ren", mem_ren, exp_ren);
            chk("m_mem_wen", mem_wen, exp_wen);
            chk("m_mem_addr", mem_addr, exp_addr);
            chk("m_mem_data_in", mem_data_in, exp_din);
            chk("m_mem_bit_sel", mem_bit_sel, exp_bsel);
            chk("m_rd_passthru", rd_data, mem_rd_data);
            if (erv != 3'b000) void'(exp_q.pop_front());
            if (!reset) begin
                exp_ren = 0;
                exp_wen = 0;
                for (int i = 0; i < 3; i++) begin
                    if (eg[i]) begin
                        a        = req_addr[i*AW +: AW];
                        exp_ren  = ~req_wr[i];
                        exp_wen  = req_wr[i];
                        exp_addr = a;
                        exp_din  = req_data[i*DW +: DW];
                        exp_bsel = req_bit_sel[i*DW +: DW];
                        if (req_wr[i])
                            ref_mem[a] = (ref_rd(a) & ~exp_bsel) | (exp_din & exp_bsel);
                        else
                            exp_q.push_back('{cyc + LAT + 1, i, ref_rd(a)});
                        ptr_m = (i + 1) % 3;
                    end
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [63:0] d, input logic [63:0] b);
        req_wr[i]              = wr;
        req_addr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]   = d;
        req_bit_sel[i*DW +: DW] = b;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] rr_tab [6];
        int peak, got, firstc, lastc;
        rr_tab[0] = 3'b001; rr_tab[1] = 3'b010; rr_tab[2] = 3'b100;
        rr_tab[3] = 3'b001; rr_tab[4] = 3'b010; rr_tab[5] = 3'b100;
        reset = 1'b1;
        req_valid = 3'b000; req_wr = 3'b000;
        req_addr = '0; req_data = '0; req_bit_sel = '0;
        tick();
        mon_en = 1'b1;
        req_valid = 3'b111;
        at_neg();
        chk("gnt_in_reset", req_gnt, 3'b000);
        chk("ren_in_reset", mem_ren, 1'b0);
        chk("pending_in_reset", rd_pending, 3'd0);
        tick();
        req_valid = 3'b000;
        reset = 1'b0;
        tick();

        // All three reading continuously
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 17'(32'h200 + i*8), '0, '0);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            at_neg();
`ifdef GLB_BANK_ARB_RR_EN
            chk("rr_gnt_seq", req_gnt, rr_tab[c]);
`else
            chk("fixed_gnt_seq", req_gnt, 3'b001);
`endif
            tick();
        end
        req_valid = 3'b000;
        repeat (6) tick();

        // Single proc read of 0x100
        set_req(0, 1'b0, 17'h100, '0, '0);
        req_valid = 3'b001;
        at_neg();
        chk("single_gnt", req_gnt, 3'b001);
        tick();
        req_valid = 3'b000;
        at_neg();
        chk("single_ren", mem_ren, 1'b1);
        chk("single_addr", mem_addr, 17'h100);
        chk("single_pend1", rd_pending, 3'd1);
        tick(); tick(); tick();
        at_neg();
        chk("single_rd_valid", rd_valid, 3'b001);
        chk("single_rd_data", rd_data, 64'hA5A5);
        tick();
        at_neg();
        chk("single_pend0", rd_pending, 3'd0);
        chk("single_rd_off", rd_valid, 3'b000);
        tick();

        // Four back-to-back strm reads
        for (int c = 0; c < 4; c++) begin
            set_req(1, 1'b0, 17'(c*8), '0, '0);
            req_valid = 3'b010;
            at_neg();
            chk("strm_gnt", req_gnt, 3'b010);
            tick();
        end
        req_valid = 3'b000;
        peak = 0; got = 0; firstc = -1; lastc = -1;
        for (int c = 0; c < 8; c++) begin
            at_neg();
            if (int'(rd_pending) > peak) peak = int'(rd_pending);
            if (rd_valid == 3'b010) begin
                chk("strm_data", rd_data, 64'h1000_0000_0000_0000 + 64'(got*8));
                if (firstc < 0) firstc = c;
                lastc = c;
                got++;
            end
            tick();
        end
        chk("strm_count", 64'(got), 64'd4);
        chk("strm_consec", 64'(lastc - firstc), 64'd3);
        chk("strm_peak", 64'(peak), 64'd4);

        // cfg masked write then proc read of the same word
        set_req(2, 1'b1, 17'h40, 64'hFFFF, 64'h00FF);
        req_valid = 3'b100;
        at_neg();
        chk("cfg_wr_gnt", req_gnt, 3'b100);
        tick();
        req_wr = 3'b000;
        set_req(0, 1'b0, 17'h40, '0, '0);
        req_valid = 3'b001;
        at_neg();
        chk("wr_wen", mem_wen, 1'b1);
        chk("wr_ren", mem_ren, 1'b0);
        chk("rd_after_wr_gnt", req_gnt, 3'b001);
        tick();
        req_valid = 3'b000;
        at_neg();
        chk("rd_after_wr_ren", mem_ren, 1'b1);
        chk("rd_after_wr_addr", mem_addr, 17'h40);
        tick(); tick();
        at_neg();
        chk("no_wr_response", rd_valid, 3'b000);
        tick();
        at_neg();
        chk("merged_rd_valid", rd_valid, 3'b001);
        chk("merged_rd_data", rd_data, 64'h1000_0000_0000_00FF);
        tick();

        // Idle: nothing granted, address held, pointer kept
        for (int c = 0; c < 10; c++) begin
            at_neg();
            chk("idle_gnt", req_gnt, 3'b000);
            chk("idle_ren", mem_ren, 1'b0);
            chk("idle_wen", mem_wen, 1'b0);
            chk("idle_addr_held", mem_addr, 17'h40);
            tick();
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 17'(32'h280 + i*8), '0, '0);
        req_valid = 3'b111;
        at_neg();
`ifdef GLB_BANK_ARB_RR_EN
        chk("ptr_after_idle", req_gnt, 3'b010);
`else
        chk("prio_after_idle", req_gnt, 3'b001);
`endif
        tick();
        req_valid = 3'b000;
        repeat (6) tick();

        // Reset with reads in flight
        set_req(0, 1'b0, 17'h300, '0, '0);
        req_valid = 3'b001;
        tick();
        set_req(0, 1'b0, 17'h308, '0, '0);
        tick();
        req_valid = 3'b000;
        chk("pre_reset_ren", mem_ren, 1'b1);
        reset = 1'b1;
        #1;
        chk("reset_ren_clear", mem_ren, 1'b0);
        chk("reset_pend_clear", rd_pending, 3'd0);
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            at_neg();
            chk("no_rd_after_reset", rd_valid, 3'b000);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
